// File: rtl/bcd_to_bin_16bit_pkg.sv
// Shared definitions for the 5-digit BCD to 16-bit binary converter:
// state encoding, conversion constants and a digit-validity helper.
package bcd_to_bin_16bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          SHIFT_COUNT = 17;
    localparam int          BCD_DIGITS  = 5;
    localparam int          BCD_W       = 4 * BCD_DIGITS;
    localparam int          RES_W       = 17;
    localparam int          CNT_W       = 5;
    localparam logic [15:0] SAT_VALUE   = 16'hFFFF;

    // True when any 4-bit digit of the packed BCD word is outside 0..9.
    function automatic logic bcd_word_invalid(input logic [BCD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (word[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_16bit_sub3.sv
// Combinational BCD digit corrector for the right-shifting (reverse
// double-dabble) conversion: digits of 8 or more have 3 removed.
module bcd_to_bin_16bit_sub3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A right shift that carries a 1 into a digit MSB adds 8 instead of 5.
    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_to_bin_16bit.sv
// Sequential 5-digit BCD to 16-bit binary converter: 17 shift steps,
// saturating result with overflow flag, and invalid-digit error path.
module bcd_to_bin_16bit
    import bcd_to_bin_16bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ten_thousands,
    input  logic [3:0]  thousands,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  units,
    output logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err
);

    state_t             state_r;
    state_t             state_s;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_shift_s;
    logic [BCD_W-1:0]   bcd_corr_s;
    logic [BCD_W-1:0]   bcd_in_s;
    logic [RES_W-1:0]   res_r;
    logic [RES_W-1:0]   res_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               bad_s;
    logic               last_s;
    logic               accept_s;

    logic [15:0]        b_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic               err_r;
    logic [15:0]        b_s;
    logic               busy_s;
    logic               done_s;
    logic               ovf_s;
    logic               err_s;

    assign bcd_in_s    = {ten_thousands, thousands, hundreds, tens, units};
    assign bad_s       = bcd_word_invalid(bcd_in_s);
    assign accept_s    = (state_r == IDLE) && start && !bad_s;
    assign last_s      = (cnt_r == CNT_W'(SHIFT_COUNT - 1));
    assign bcd_shift_s = {1'b0, bcd_r[BCD_W-1:1]};
    assign res_next_s  = {bcd_r[0], res_r[RES_W-1:1]};

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_corr
        bcd_to_bin_16bit_sub3 u_sub3 (
            .din  (bcd_shift_s[4*gi +: 4]),
            .dout (bcd_corr_s[4*gi +: 4])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = bad_s ? DONE : SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; results hold between conversions.
    always_comb begin
        b_s    = b_r;
        ovf_s  = ovf_r;
        err_s  = err_r;
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
        case (state_r)
            IDLE: begin
                if (start && bad_s) begin
                    b_s   = 16'h0000;
                    ovf_s = 1'b0;
                    err_s = 1'b1;
                end else begin
                    b_s   = b_r;
                end
            end
            SHIFT: begin
                if (last_s && res_next_s[RES_W-1]) begin
                    b_s   = SAT_VALUE;
                    ovf_s = 1'b1;
                    err_s = 1'b0;
                end else if (last_s) begin
                    b_s   = res_next_s[15:0];
                    ovf_s = 1'b0;
                    err_s = 1'b0;
                end else begin
                    b_s   = b_r;
                end
            end
            default: begin
                b_s = b_r;
            end
        endcase
    end

    // Conversion datapath: load on accepted start, shift-and-correct in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r <= {BCD_W{1'b0}};
            res_r <= {RES_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            bcd_r <= bcd_in_s;
            res_r <= {RES_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == SHIFT) begin
            bcd_r <= bcd_corr_s;
            res_r <= res_next_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bcd_r <= bcd_r;
            res_r <= res_r;
            cnt_r <= cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r    <= 16'h0000;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            b_r    <= b_s;
            busy_r <= busy_s;
            done_r <= done_s;
            ovf_r  <= ovf_s;
            err_r  <= err_s;
        end
    end

    assign B    = b_r;
    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_to_bin_16bit.sv
// Directed self-checking bench for bcd_to_bin_16bit.
module tb_bcd_to_bin_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ten_thousands;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        err;

    int n_checks;
    int n_fail;
    int cyc;
    logic busy_at_done;

    bcd_to_bin_16bit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ten_thousands (ten_thousands),
        .thousands     (thousands),
        .hundreds      (hundreds),
        .tens          (tens),
        .units         (units),
        .B             (B),
        .busy          (busy),
        .done          (done),
        .ovf           (ovf),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        ten_thousands = d4;
        thousands     = d3;
        hundreds      = d2;
        tens          = d1;
        units         = d0;
    endtask

    // Count negedges after the start edge until done, bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        busy_at_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    task automatic convert(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0, output int n);
        @(negedge clk);
        set_digits(d4, d3, d2, d1, d0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
    endtask

    task automatic conv_check(input string tag, input logic [3:0] d4, input logic [3:0] d3,
                              input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                              input logic [15:0] exp_b, input logic exp_ovf);
        int n;
        convert(d4, d3, d2, d1, d0, n);
        check({tag, "_lat"}, n, 18);
        check({tag, "_B"}, B, exp_b);
        check({tag, "_ovf"}, ovf, exp_ovf);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int vals[15];
        int x;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_B", B, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // All-zero input: latency and busy during DONE.
        convert(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, cyc);
        check("zero_lat", cyc, 18);
        check("zero_busy", busy_at_done, 1'b1);
        check("zero_B", B, 16'h0000);
        check("zero_ovf", ovf, 1'b0);
        check("zero_err", err, 1'b0);

        conv_check("v12345", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0);
        @(negedge clk);
        check("hold_done", done, 1'b0);
        check("hold_busy", busy, 1'b0);
        check("hold_B", B, 16'h3039);

        conv_check("v65535", 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'hFFFF, 1'b0);
        conv_check("v65536", 4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 16'hFFFF, 1'b1);
        conv_check("v99999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 16'hFFFF, 1'b1);

        // Invalid digit: immediate done with err.
        convert(4'd0, 4'd0, 4'd0, 4'hA, 4'd0, cyc);
        check("inv_lat", cyc, 1);
        check("inv_err", err, 1'b1);
        check("inv_B", B, 16'h0000);
        check("inv_ovf", ovf, 1'b0);
        conv_check("v42", 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0);

        // Start during SHIFT ignored; digit changes during SHIFT ignored.
        @(negedge clk);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ign_lat", cyc, 13);
        check("ign_B", B, 16'h3039);
        check("ign_ovf", ovf, 1'b0);
        repeat (3) @(negedge clk);
        check("ign_noqueue", busy, 1'b0);

        // Reset during SHIFT aborts with no done.
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_B", B, 16'h0000);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        check("abort_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(cyc);
        check("abort_nodone", cyc, 0);
        conv_check("v06553", 4'd0, 4'd6, 4'd5, 4'd5, 4'd3, 16'h1999, 1'b0);

        // Start held high re-triggers on the first IDLE edge.
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd7, 4'd0, 4'd0);
        start = 1'b1;
        @(posedge clk);
        wait_done(cyc);
        check("held_lat1", cyc, 18);
        wait_done(cyc);
        check("held_lat2", cyc, 19);
        check("held_B", B, 16'h02BC);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);

        // Round trip over boundary values: binary -> BCD digits -> binary.
        vals = '{0, 1, 9, 10, 99, 100, 255, 256, 4095, 9999, 10000, 32767, 32768, 65534, 65535};
        for (int i = 0; i < 15; i++) begin
            x = vals[i];
            conv_check($sformatf("rt%0d", x), 4'(x / 10000), 4'((x / 1000) % 10),
                       4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10), 16'(x), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_16bit.md
BCD_TO_BIN_16BIT -- requirements
Module: bcd_to_bin_16bit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named as the codebase names its clock and reset ports.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  conversion request; sampled only in IDLE.
REQ-005 Port: ten_thousands  input  4  BCD digit, weight 10000.
REQ-006 Port: thousands  input  4  BCD digit, weight 1000.
REQ-007 Port: hundreds  input  4  BCD digit, weight 100.
REQ-008 Port: tens  input  4  BCD digit, weight 10.
REQ-009 Port: units  input  4  BCD digit, weight 1.
REQ-010 Port: B  output  16  binary result; holds its value until the next completed conversion.
REQ-011 Port: busy  output  1  high in SHIFT and DONE.
REQ-012 Port: done  output  1  one-cycle pulse; B, ovf and err are valid in that cycle.
REQ-013 Port: ovf  output  1  the BCD value exceeds 65535.
REQ-014 Port: err  output  1  at least one digit is greater than 9.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 IDLE, start=1 at edge k, all digits <=9: capture the 20-bit BCD word {ten_thousands..units}, clear the 17-bit result register and the counter, then go to SHIFT.
REQ-017 IDLE, start=1 at edge k, any digit >9: go to DONE; at the same edge set B=16'h0000, err=1, ovf=0.
REQ-018 Each SHIFT edge SHALL shift the BCD word right 1 bit, with its LSB entering the result MSB (result shifts right); then every 4-bit digit >=8 SHALL have 3 subtracted.
REQ-019 SHIFT SHALL perform exactly 17 shifts, on edges k+1 to k+17; the 17th shift SHALL go to DONE and register the outputs.
REQ-020 Registered outputs for a valid conversion: result <=65535 gives B=result[15:0], ovf=0; result >65535 gives B=16'hFFFF (saturated), ovf=1; err=0 in both cases.
REQ-021 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-022 Latency: for valid input, done is high in the cycle after edge k+17; for invalid input, done is high in the cycle after edge k.
REQ-023 start SHALL be ignored in SHIFT and DONE; no request is queued. start held high re-triggers on the first IDLE edge.
REQ-024 Digit inputs SHALL be sampled only at the start edge; changes during SHIFT have no effect.
REQ-025 ovf and err SHALL keep their values until the next completed conversion, as B does.

Reset
REQ-026 When rst_n=0, the state SHALL go to IDLE asynchronously; B=0, busy=0, done=0, ovf=0, err=0, and internal registers are cleared.
REQ-027 A reset during SHIFT SHALL abort the conversion with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-028 A shared package SHALL hold: the state encoding (IDLE/SHIFT/DONE), SHIFT_COUNT=17, BCD_DIGITS=5 and SAT_VALUE=16'hFFFF.
REQ-029 One sub-module, sub3, SHALL be instantiated 5 times: a combinational 4-bit digit corrector with out = in>=8 ? in-3 : in.
REQ-030 The block SHALL form a round-trip pair with bcd_decoder_16bit: for every 16-bit value X, converting X to BCD and back SHALL give X.

Verification
REQ-031 Digits 0,0,0,0,0 with start -> done 18 cycles after the start edge; B=16'h0000, ovf=0, err=0.
REQ-032 Digits 1,2,3,4,5 -> B=16'h3039; digits 6,5,5,3,5 -> B=16'hFFFF, ovf=0.
REQ-033 Digits 6,5,5,3,6 -> B=16'hFFFF, ovf=1; digits 9,9,9,9,9 -> B=16'hFFFF, ovf=1.
REQ-034 tens=4'hA -> done in the next cycle with err=1, B=16'h0000; a following valid conversion clears err.
REQ-035 Start 1,2,3,4,5, then pulse start with 9,9,9,9,9 at cycle 5 -> the second start is ignored and the result is 16'h3039; drop rst_n at cycle 10 of a new conversion -> no done pulse, all outputs 0.
REQ-036 Exhaustive round trip X=0..65535 through bcd_decoder_16bit into this block -> B==X, ovf=0, err=0 for every X.
